ysyx_24100029_ifu_prefetch: RTL

//  Parametrised instruction fetch unit with prefetch queue. It keeps up to MAX_OUTSTANDING single-beat
//  AXI4 reads in flight and buffers returned instructions in a FIFO_DEPTH-entry queue.
//  It feeds IDU over a valid/ready handshake. A redirect (branch/jump/trap) flushes the queue and discards
//  in-flight wrong-path responses. Read-only AXI master; the AW/W/B channels are tied off in the wrapper.

---
 rtl/ysyx_24100029_ifu_prefetch.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_24100029_ifu_prefetch.sv
// Instruction fetch unit: single-beat AXI4 reads with a prefetch queue and redirect flush.
// Optional IFU_PERF_CNT_EN adds fetch/drop/stall performance counter outputs.
module ysyx_24100029_ifu_prefetch #(
    parameter logic [31:0] RESET_PC        = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ID_W            = 4
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            redirect_i,
    input  logic [31:0]     redirect_pc_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [31:0]     pc_o,
    output logic [31:0]     inst_o,
    output logic            fault_o,
    output logic            arvalid_o,
    input  logic            arready_i,
    output logic [31:0]     araddr_o,
    output logic [ID_W-1:0] arid_o,
    output logic [7:0]      arlen_o,
    output logic [2:0]      arsize_o,
    output logic [1:0]      arburst_o,
    input  logic            rvalid_i,
    output logic            rready_o,
    input  logic [31:0]     rdata_i,
    input  logic [1:0]      rresp_i,
    input  logic            rlast_i,
    input  logic [ID_W-1:0] rid_i,
    output logic            req_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt_o,
    output logic [31:0]     drop_cnt_o,
    output logic [31:0]     stall_cnt_o
`endif
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CntW-1:0] CntOne = 1;
    localparam logic [PtrW:0] PtrOne = 1;
    localparam logic [PtrW:0] DepthP = (PtrW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {ArIdle, ArWait} ar_state_e;

    ar_state_e       ar_state_q;
    logic            arvalid_q;
    logic [31:0]     araddr_q, fetch_pc_q, resp_pc_q;
    logic [CntW-1:0] out_cnt_q, out_cnt_d, disc_cnt_q, disc_cnt_d;
    logic            stale_q, stale_d;
    logic [PtrW:0]   wr_ptr_q, rd_ptr_q, q_count;
    logic [64:0]     mem_q [FIFO_DEPTH];
    logic            ar_acc, drop, push, pop, q_empty, q_full, issue_ok;
    logic [31:0]     slots_used;
    logic [31:0]     redirect_pc_al;

    assign arvalid_o      = arvalid_q;
    assign req_o          = arvalid_q;
    assign araddr_o       = araddr_q;
    assign arid_o         = '0;
    assign arlen_o        = 8'd0;
    assign arsize_o       = 3'b010;
    assign arburst_o      = 2'b01;
    assign rready_o       = 1'b1;
    assign redirect_pc_al = {redirect_pc_i[31:2], 2'b00};

    assign q_count = wr_ptr_q - rd_ptr_q;
    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign q_full  = (q_count == DepthP);
    assign valid_o = !q_empty && !redirect_i;
    assign {pc_o, inst_o, fault_o} = mem_q[rd_ptr_q[PtrW-1:0]];

    assign ar_acc = arvalid_q && arready_i;
    // Beats of wrong-path requests (and any beat racing a redirect) never reach the queue.
    assign drop   = rvalid_i && (redirect_i || disc_cnt_q != '0);
    assign push   = rvalid_i && !drop;
    assign pop    = valid_o && ready_i;

    // In-flight good requests already own a queue slot, so overflow cannot occur.
    assign slots_used = 32'(q_count) + 32'(out_cnt_q) - 32'(disc_cnt_q);
    assign issue_ok   = (32'(out_cnt_q) < MAX_OUTSTANDING) && (slots_used < FIFO_DEPTH)
                        && !redirect_i;

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (ar_acc && !rvalid_i) out_cnt_d = out_cnt_q + CntOne;
        if (!ar_acc && rvalid_i) out_cnt_d = out_cnt_q - CntOne;

        disc_cnt_d = disc_cnt_q;
        if (rvalid_i && disc_cnt_q != '0) disc_cnt_d = disc_cnt_d - CntOne;
        if (ar_acc && stale_q) disc_cnt_d = disc_cnt_d + CntOne;
        // Everything still in flight after a redirect belongs to the old path.
        if (redirect_i) disc_cnt_d = out_cnt_d;

        stale_d = stale_q;
        if (redirect_i) stale_d = (ar_state_q == ArWait) && !ar_acc;
        else if (ar_acc) stale_d = 1'b0;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ar_state_q <= ArIdle;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            unique case (ar_state_q)
                ArIdle: if (issue_ok) begin
                    ar_state_q <= ArWait;
                    arvalid_q  <= 1'b1;
                    araddr_q   <= fetch_pc_q;
                end
                ArWait: if (arready_i) begin
                    ar_state_q <= ArIdle;
                    arvalid_q  <= 1'b0;
                    if (!stale_q) fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                default: ar_state_q <= ArIdle;
            endcase
            if (redirect_i) fetch_pc_q <= redirect_pc_al;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            out_cnt_q  <= '0;
            disc_cnt_q <= '0;
            stale_q    <= 1'b0;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            disc_cnt_q <= disc_cnt_d;
            stale_q    <= stale_d;
            if (redirect_i) begin
                wr_ptr_q  <= rd_ptr_q;
                resp_pc_q <= redirect_pc_al;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q[PtrW-1:0]] <= {resp_pc_q, rdata_i, rresp_i != 2'b00};
                    wr_ptr_q  <= wr_ptr_q + PtrOne;
                    resp_pc_q <= resp_pc_q + 32'd4;
                end
                if (pop) rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    no_overflow_a: assert property (@(posedge clock_i) disable iff (reset_i) push |-> !q_full);

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, drop_cnt_q, stall_cnt_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (drop) drop_cnt_q <= drop_cnt_q + 32'd1;
            if (ready_i && !valid_o) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{rlast_i, rid_i, redirect_pc_i[1:0]};

endmodule
